// File: rtl/darkfetch.sv
// darkfetch -- instruction fetch stage.
//
// Sits directly downstream of the PC sequencer. Each fetch makes one
// advance request to the sequencer and takes back the returned pc. It then
// reads that word over a req/ack instruction-memory port. The resulting
// {pc, instruction} pair is queued in a small FIFO for decode.
// A flush from execute redirects the next fetch address and empties the FIFO.
//
// Ports:
//   clk, res_n            clock, asynchronous active-low reset
//   pc_en, nxpc           advance request / load address to the sequencer
//   pc, pc_valid          sequencer's current pc and its one-cycle valid pulse
//   imem_req, imem_addr   instruction memory request and word address
//   imem_ack, imem_rdata  memory completion and data (same cycle)
//   inst_valid, inst_ready, inst, inst_pc
//                         valid/ready handshake towards decode (FIFO head)
//   flush, flush_pc       redirect from execute
module darkfetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        res_n,
  output logic        pc_en,
  output logic [31:0] nxpc,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WPC  = 2'd1,
    MEM  = 2'd2
  } state_e;

  state_e        state_q;
  logic          pc_en_q;
  logic          imem_req_q;
  logic          discard_q;
  logic [31:0]   npc_q;
  logic [31:0]   imem_addr_q;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;
  logic [31:0]   slot_pc_q   [DEPTH];
  logic [31:0]   slot_inst_q [DEPTH];
  logic [31:0]   up_pc       [DEPTH];
  logic [31:0]   up_inst     [DEPTH];

  logic          push;
  logic          pop;

  // The low two bits of pc and flush_pc are dropped; fetch is word aligned.
  logic          unused_low_bits;
  assign unused_low_bits = ^{pc[1:0], flush_pc[1:0]};

  // Flush voids any same-cycle push or pop.
  assign push = (state_q == MEM) && imem_ack && !discard_q && !flush;
  assign pop  = (count_q != '0) && inst_ready && !flush;

  // On a simultaneous pop the entries shift down by one, so the new entry
  // lands one slot lower than the current count.
  assign wr_idx = pop ? (count_q - CW'(1)) : count_q;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Shift source for each slot: the slot above it (the top slot holds,
  // its content is beyond count after a pop anyway).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_up
    if (gi < DEPTH - 1) begin : g_mid
      assign up_pc[gi]   = slot_pc_q[gi+1];
      assign up_inst[gi] = slot_inst_q[gi+1];
    end else begin : g_top
      assign up_pc[gi]   = slot_pc_q[gi];
      assign up_inst[gi] = slot_inst_q[gi];
    end
  end

  // FIFO storage: slot 0 is always the head, so the decode outputs come
  // straight from registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]   <= '0;
        slot_inst_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == CW'(i))) begin
          slot_pc_q[i]   <= imem_addr_q;
          slot_inst_q[i] <= imem_rdata;
        end else if (pop) begin
          slot_pc_q[i]   <= up_pc[i];
          slot_inst_q[i] <= up_inst[i];
        end
      end
    end
  end

  // Fetch control. pc_en_q is raised one cycle ahead while still in IDLE so
  // that the request, the pc return and the memory access each take exactly
  // one cycle and a new fetch can start right after an ack.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= IDLE;
      pc_en_q     <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      discard_q   <= 1'b0;
      npc_q       <= RESET_PC;
    end else begin
      pc_en_q <= 1'b0;
      if (flush) begin
        npc_q <= {flush_pc[31:2], 2'b00};
      end
      unique case (state_q)
        IDLE: begin
          if (pc_en_q && !flush) begin
            state_q <= WPC;
          end else begin
            // Also re-issues after a flush, so the sequencer reloads flush_pc.
            pc_en_q <= (count_d < DEPTH_C);
          end
        end
        WPC: begin
          if (flush) begin
            discard_q <= 1'b1;
          end
          if (pc_valid) begin
            state_q     <= MEM;
            imem_req_q  <= 1'b1;
            imem_addr_q <= {pc[31:2], 2'b00};
            // A pending redirect owns npc; the stale pc must not move it.
            if (!flush && !discard_q) begin
              npc_q <= pc + 32'd4;
            end
          end
        end
        MEM: begin
          // The bus transaction always runs to completion.
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            discard_q  <= 1'b0;
            state_q    <= IDLE;
            pc_en_q    <= (count_d < DEPTH_C);
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pc_en      = pc_en_q;
  assign nxpc       = npc_q;
  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = slot_inst_q[0];
  assign inst_pc    = slot_pc_q[0];

endmodule
